// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port memory bus between instruction fetch and data access.
// Define ARVI_ARB_ROUND_ROBIN_EN for round-robin contention; default is D over I.
module imem_dmem_arbiter #(
  parameter int XLEN = 32,
  parameter int BE_W = XLEN / 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_IC_DataReq,
  input  logic [XLEN-1:0] i_IM_Addr,
  output logic [XLEN-1:0] o_IM_Instr,
  output logic            o_IC_MemReady,
  input  logic            i_DM_MemRead,
  input  logic            i_DM_Wen,
  input  logic [XLEN-1:0] i_DM_Addr,
  input  logic [XLEN-1:0] i_DM_Wd,
  input  logic [BE_W-1:0] i_DM_byte_en,
  output logic [XLEN-1:0] o_DM_ReadData,
  output logic            o_DM_data_ready,
  output logic            o_MEM_req,
  output logic            o_MEM_we,
  output logic [XLEN-1:0] o_MEM_addr,
  output logic [XLEN-1:0] o_MEM_wdata,
  output logic [BE_W-1:0] o_MEM_byte_en,
  input  logic [XLEN-1:0] i_MEM_rdata,
  input  logic            i_MEM_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SERVE,
    S_RESP
  } state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              req_q, req_d;
  logic              ic_rdy_q, ic_rdy_d;
  logic              dm_rdy_q, dm_rdy_d;

  logic              d_req;
  logic              i_req;
  logic              grant_d;

  assign d_req = i_DM_Wen | i_DM_MemRead;
  assign i_req = i_IC_DataReq;

`ifdef ARVI_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  // On contention the side that did not win last time goes next.
  always_comb begin
    if (d_req && i_req) grant_d = (last_q == OWN_I);
    else                grant_d = d_req;
  end
`else
  assign grant_d = d_req;
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    instr_d  = instr_q;
    rdata_d  = rdata_q;
    req_d    = 1'b0;
    ic_rdy_d = 1'b0;
    dm_rdy_d = 1'b0;
`ifdef ARVI_ARB_ROUND_ROBIN_EN
    last_d   = last_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (d_req || i_req) begin
          state_d = S_SERVE;
          req_d   = 1'b1;
          owner_d = grant_d;
`ifdef ARVI_ARB_ROUND_ROBIN_EN
          last_d  = grant_d;
`endif
          if (grant_d == OWN_D) begin
            we_d    = i_DM_Wen;
            addr_d  = i_DM_Addr;
            wdata_d = i_DM_Wd;
            be_d    = i_DM_byte_en;
          end else begin
            we_d    = 1'b0;
            addr_d  = i_IM_Addr;
            wdata_d = '0;
            be_d    = '1;
          end
        end
      end
      S_SERVE: begin
        if (i_MEM_ready) begin
          state_d = S_RESP;
          if (owner_q == OWN_I) begin
            instr_d  = i_MEM_rdata;
            ic_rdy_d = 1'b1;
          end else begin
            if (!we_q) rdata_d = i_MEM_rdata;
            dm_rdy_d = 1'b1;
          end
        end else begin
          req_d = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_I;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      instr_q  <= '0;
      rdata_q  <= '0;
      req_q    <= 1'b0;
      ic_rdy_q <= 1'b0;
      dm_rdy_q <= 1'b0;
`ifdef ARVI_ARB_ROUND_ROBIN_EN
      last_q   <= OWN_D;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      instr_q  <= instr_d;
      rdata_q  <= rdata_d;
      req_q    <= req_d;
      ic_rdy_q <= ic_rdy_d;
      dm_rdy_q <= dm_rdy_d;
`ifdef ARVI_ARB_ROUND_ROBIN_EN
      last_q   <= last_d;
`endif
    end
  end

  assign o_MEM_req       = req_q;
  assign o_MEM_we        = we_q;
  assign o_MEM_addr      = addr_q;
  assign o_MEM_wdata     = wdata_q;
  assign o_MEM_byte_en   = be_q;
  assign o_IM_Instr      = instr_q;
  assign o_DM_ReadData   = rdata_q;
  assign o_IC_MemReady   = ic_rdy_q;
  assign o_DM_data_ready = dm_rdy_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: per-cycle vector table plus
// hand-written sequences for data paths, contention and mid-transaction reset.
module tb_imem_dmem_arbiter;

  localparam int XLEN = 32;
  localparam int BE_W = 4;

  logic            clk;
  logic            rst;
  logic            ic_req;
  logic [XLEN-1:0] im_addr;
  logic [XLEN-1:0] im_instr;
  logic            ic_rdy;
  logic            dm_rd;
  logic            dm_wen;
  logic [XLEN-1:0] dm_addr;
  logic [XLEN-1:0] dm_wd;
  logic [BE_W-1:0] dm_be;
  logic [XLEN-1:0] dm_rdata;
  logic            dm_rdy;
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [BE_W-1:0] mem_be;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_rdy;

  int n_cmp;
  int n_err;

  imem_dmem_arbiter #(.XLEN(XLEN), .BE_W(BE_W)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_IC_DataReq   (ic_req),
    .i_IM_Addr      (im_addr),
    .o_IM_Instr     (im_instr),
    .o_IC_MemReady  (ic_rdy),
    .i_DM_MemRead   (dm_rd),
    .i_DM_Wen       (dm_wen),
    .i_DM_Addr      (dm_addr),
    .i_DM_Wd        (dm_wd),
    .i_DM_byte_en   (dm_be),
    .o_DM_ReadData  (dm_rdata),
    .o_DM_data_ready(dm_rdy),
    .o_MEM_req      (mem_req),
    .o_MEM_we       (mem_we),
    .o_MEM_addr     (mem_addr),
    .o_MEM_wdata    (mem_wdata),
    .o_MEM_byte_en  (mem_be),
    .i_MEM_rdata    (mem_rdata),
    .i_MEM_ready    (mem_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic ic;
    logic rd;
    logic wen;
    logic mrdy;
    logic e_req;
    logic e_we;
    logic e_icr;
    logic e_dmr;
  } vec_t;

  vec_t vt [26];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ic_req  = 1'b0;
    dm_rd   = 1'b0;
    dm_wen  = 1'b0;
    mem_rdy = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] grants [4];
    logic [1:0] exp_g  [4];
    int         np;
    int         nreq;

    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    im_addr   = 32'h0000_0100;
    dm_addr   = 32'h0000_2004;
    dm_wd     = 32'hDEAD_BEEF;
    dm_be     = 4'b0011;
    mem_rdata = 32'h0000_0013;
    idle_inputs();

    // Columns: ic rd wen mrdy | req we icr dmr (we checked only with req)
    vt[0]  = '{1,0,0,1, 0,0,0,0};
    vt[1]  = '{1,0,0,1, 1,0,0,0};
    vt[2]  = '{1,0,0,1, 0,0,1,0};
    vt[3]  = '{0,0,0,1, 0,0,0,0};
    vt[4]  = '{0,0,1,0, 0,0,0,0};
    vt[5]  = '{0,0,1,0, 1,1,0,0};
    vt[6]  = '{0,0,1,0, 1,1,0,0};
    vt[7]  = '{0,0,1,0, 1,1,0,0};
    vt[8]  = '{0,0,1,1, 1,1,0,0};
    vt[9]  = '{0,0,1,0, 0,0,0,1};
    vt[10] = '{0,1,0,0, 0,0,0,0};
    vt[11] = '{0,1,0,0, 1,0,0,0};
    vt[12] = '{0,1,0,1, 1,0,0,0};
    vt[13] = '{0,0,0,0, 0,0,0,1};
    vt[14] = '{1,0,0,0, 0,0,0,0};
    vt[15] = '{0,0,0,0, 1,0,0,0};
    vt[16] = '{0,0,0,1, 1,0,0,0};
    vt[17] = '{0,0,0,0, 0,0,1,0};
    vt[18] = '{0,0,0,1, 0,0,0,0};
    vt[19] = '{1,0,0,1, 0,0,0,0};
    vt[20] = '{1,0,0,1, 1,0,0,0};
    vt[21] = '{1,0,0,1, 0,0,1,0};
    vt[22] = '{1,0,0,1, 0,0,0,0};
    vt[23] = '{1,0,0,1, 1,0,0,0};
    vt[24] = '{1,0,0,1, 0,0,1,0};
    vt[25] = '{0,0,0,0, 0,0,0,0};

    // Reset state
    repeat (2) tick();
    @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_ready", {30'b0, ic_rdy, dm_rdy}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
    chk("rst_instr", im_instr, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Cycle-by-cycle control vectors
    for (int i = 0; i < 26; i++) begin
      ic_req  = vt[i].ic;
      dm_rd   = vt[i].rd;
      dm_wen  = vt[i].wen;
      mem_rdy = vt[i].mrdy;
      @(negedge clk);
      chk($sformatf("vec%0d_req", i), {31'b0, mem_req}, {31'b0, vt[i].e_req});
      if (vt[i].e_req)
        chk($sformatf("vec%0d_we", i), {31'b0, mem_we}, {31'b0, vt[i].e_we});
      chk($sformatf("vec%0d_icr", i), {31'b0, ic_rdy}, {31'b0, vt[i].e_icr});
      chk($sformatf("vec%0d_dmr", i), {31'b0, dm_rdy}, {31'b0, vt[i].e_dmr});
      tick();
    end
    idle_inputs();
    tick();

    // Lone fetch, zero-wait memory
    im_addr   = 32'h0000_0100;
    mem_rdata = 32'h0000_0013;
    ic_req    = 1'b1;
    mem_rdy   = 1'b1;
    @(negedge clk);
    chk("lf_c0_req", {31'b0, mem_req}, 32'd0);
    tick();
    @(negedge clk);
    chk("lf_c1_req", {31'b0, mem_req}, 32'd1);
    chk("lf_c1_addr", mem_addr, 32'h0000_0100);
    chk("lf_c1_be", {28'b0, mem_be}, 32'hF);
    chk("lf_c1_we", {31'b0, mem_we}, 32'd0);
    tick();
    @(negedge clk);
    chk("lf_c2_icr", {31'b0, ic_rdy}, 32'd1);
    chk("lf_c2_instr", im_instr, 32'h0000_0013);
    ic_req = 1'b0;
    tick();
    @(negedge clk);
    chk("lf_c3_icr", {31'b0, ic_rdy}, 32'd0);
    tick();

    // Data read to seed o_DM_ReadData
    dm_addr   = 32'h0000_3000;
    mem_rdata = 32'hCAFE_0001;
    dm_rd     = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("rd_dmr", {31'b0, dm_rdy}, 32'd1);
    chk("rd_data", dm_rdata, 32'hCAFE_0001);
    idle_inputs();
    tick();

    // Data write with 3 wait cycles
    dm_addr   = 32'h0000_2004;
    dm_wd     = 32'hDEAD_BEEF;
    dm_be     = 4'b0011;
    mem_rdata = 32'h5555_5555;
    dm_wen    = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      mem_rdy = (k == 3);
      @(negedge clk);
      chk($sformatf("wr%0d_req", k), {31'b0, mem_req}, 32'd1);
      chk($sformatf("wr%0d_we", k), {31'b0, mem_we}, 32'd1);
      chk($sformatf("wr%0d_addr", k), mem_addr, 32'h0000_2004);
      chk($sformatf("wr%0d_wdata", k), mem_wdata, 32'hDEAD_BEEF);
      chk($sformatf("wr%0d_be", k), {28'b0, mem_be}, 32'h3);
      chk($sformatf("wr%0d_dmr", k), {31'b0, dm_rdy}, 32'd0);
      tick();
    end
    mem_rdy = 1'b0;
    @(negedge clk);
    chk("wr_dmr", {31'b0, dm_rdy}, 32'd1);
    chk("wr_req_off", {31'b0, mem_req}, 32'd0);
    chk("wr_rdata_kept", dm_rdata, 32'hCAFE_0001);
    idle_inputs();
    tick();

    // Wen and MemRead together: treated as write
    mem_rdata = 32'h7777_7777;
    dm_wen    = 1'b1;
    dm_rd     = 1'b1;
    mem_rdy   = 1'b1;
    tick();
    @(negedge clk);
    chk("wr_rd_we", {31'b0, mem_we}, 32'd1);
    tick();
    @(negedge clk);
    chk("wr_rd_dmr", {31'b0, dm_rdy}, 32'd1);
    chk("wr_rd_rdata", dm_rdata, 32'hCAFE_0001);
    idle_inputs();
    tick();

    // Contention, requests held, four grants observed
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    im_addr   = 32'h0000_0100;
    dm_addr   = 32'h0000_2004;
    mem_rdata = 32'h0000_0042;
    ic_req    = 1'b1;
    dm_rd     = 1'b1;
    mem_rdy   = 1'b1;
`ifdef ARVI_ARB_ROUND_ROBIN_EN
    exp_g = '{2'd1, 2'd2, 2'd1, 2'd2};
`else
    exp_g = '{2'd2, 2'd2, 2'd2, 2'd2};
`endif
    np   = 0;
    nreq = 0;
    for (int c = 0; c < 40 && np < 4; c++) begin
      @(negedge clk);
      if (mem_req) nreq++;
      if (ic_rdy || dm_rdy) begin
        grants[np] = {dm_rdy, ic_rdy};
        np++;
      end
      tick();
    end
    chk("cont_pulses", np, 32'd4);
    chk("cont_req_cycles", nreq, 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < np)
        chk($sformatf("cont_grant%0d", k), {30'b0, grants[k]},
            {30'b0, exp_g[k]});
    idle_inputs();
    tick();
    tick();

    // Reset asserted during SERVE with memory stalled
    im_addr = 32'h0000_0200;
    ic_req  = 1'b1;
    mem_rdy = 1'b0;
    tick();
    @(negedge clk);
    chk("mr_serve_req", {31'b0, mem_req}, 32'd1);
    tick();
    rst    = 1'b1;
    ic_req = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mr_req_off", {31'b0, mem_req}, 32'd0);
    chk("mr_no_pulse", {30'b0, ic_rdy, dm_rdy}, 32'd0);
    tick();
    @(negedge clk);
    chk("mr_idle_req", {31'b0, mem_req}, 32'd0);
    chk("mr_idle_pulse", {30'b0, ic_rdy, dm_rdy}, 32'd0);
    mem_rdata = 32'h00A0_0093;
    ic_req    = 1'b1;
    mem_rdy   = 1'b1;
    tick();
    @(negedge clk);
    chk("mr_new_req", {31'b0, mem_req}, 32'd1);
    chk("mr_new_addr", mem_addr, 32'h0000_0200);
    tick();
    @(negedge clk);
    chk("mr_new_icr", {31'b0, ic_rdy}, 32'd1);
    chk("mr_new_instr", im_instr, 32'h00A0_0093);
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
